// File: rtl/lava_pkg.sv
// lava_pkg: shared definitions for the LAVA token codec (encoder, decoder, bench).
//   lava_idx_width(n) : width of an index field able to address n samples
//   lava_token_t      : token {value, index} for the default configuration
//   lava_state_t      : decoder sequencing states
package lava_pkg;

    localparam int LAVA_DATA_BITS = 10;
    localparam int LAVA_SAMPLES   = 3328;

    function automatic int lava_idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int LAVA_IDX_W = lava_idx_width(LAVA_SAMPLES);

    typedef struct packed {
        logic [LAVA_DATA_BITS-1:0] value;
        logic [LAVA_IDX_W-1:0]     index;
    } lava_token_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } lava_state_t;

endpackage

// File: rtl/lava_tok_buf.sv
// lava_tok_buf: one-entry token holding slot with same-cycle refill.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   i_data        : entry to store
//   i_wr          : store i_data (only asserted while o_ready is high)
//   i_consume     : current entry is used up this cycle
//   o_data/o_valid: held entry and its valid flag
//   o_ready       : slot can take a new entry this cycle
module lava_tok_buf #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] i_data,
    input  logic             i_wr,
    input  logic             i_consume,
    output logic [Width-1:0] o_data,
    output logic             o_valid,
    output logic             o_ready
);

    logic [Width-1:0] r_data;
    logic             r_valid;

    // A slot freed by this cycle's consume can be refilled in the same cycle.
    assign o_ready = !r_valid || i_consume;
    assign o_data  = r_data;
    assign o_valid = r_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_wr) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lava_decoder.sv
// lava_decoder: rebuilds the full per-channel sample stream from LAVA tokens
// by sample-and-hold expansion, one sample per cycle under valid/ready.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   tok_i            : token {value[MSBs], index[LSBs]}
//   tok_last_i       : token closes its frame
//   tok_valid_i/tok_ready_o : token handshake
//   sample_o, sample_idx_o, sample_last_o : reconstructed sample, position, frame end
//   sample_valid_o/sample_ready_i         : sample handshake
//   err_o            : sticky protocol error (out-of-order or out-of-range index)
module lava_decoder
    import lava_pkg::*;
#(
    parameter  int Data_bits           = 10,
    parameter  int Samples_per_channel = 3328,
    localparam int Index_width         = lava_idx_width(Samples_per_channel)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [Data_bits+Index_width-1:0] tok_i,
    input  logic                             tok_last_i,
    input  logic                             tok_valid_i,
    output logic                             tok_ready_o,
    output logic [Data_bits-1:0]             sample_o,
    output logic [Index_width-1:0]           sample_idx_o,
    output logic                             sample_last_o,
    output logic                             sample_valid_o,
    input  logic                             sample_ready_i,
    output logic                             err_o
);

    localparam int                     BufW    = Data_bits + Index_width + 1;
    localparam logic [Index_width-1:0] LastPos = Index_width'(Samples_per_channel - 1);

    logic [BufW-1:0]        w_buf_data;
    logic                   w_buf_valid;
    logic                   w_buf_ready;
    logic [Data_bits-1:0]   w_buf_val;
    logic [Index_width-1:0] w_buf_idx;
    logic                   w_buf_last;
    logic [Index_width-1:0] w_tok_idx;
    logic                   w_tok_bad;
    logic                   w_accept;
    logic                   w_store;
    logic                   w_adv;
    logic                   w_emit;
    logic [Data_bits-1:0]   w_emit_val;
    logic                   w_consume;
    logic [Index_width-1:0] w_pos_inc;
    logic [Index_width-1:0] w_pos_nxt;
    lava_state_t            w_state_nxt;

    lava_state_t            r_state;
    logic [Index_width-1:0] r_pos;
    logic [Data_bits-1:0]   r_hold;
    logic [Data_bits-1:0]   r_sample;
    logic [Index_width-1:0] r_idx;
    logic                   r_last;
    logic                   r_valid;
    logic                   r_err;

    assign {w_buf_val, w_buf_idx, w_buf_last} = w_buf_data;

    lava_tok_buf #(
        .Width(BufW)
    ) u_tok_buf (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_data   ({tok_i, tok_last_i}),
        .i_wr     (w_store),
        .i_consume(w_consume),
        .o_data   (w_buf_data),
        .o_valid  (w_buf_valid),
        .o_ready  (w_buf_ready)
    );

    assign w_adv     = !r_valid || sample_ready_i;
    assign w_pos_inc = (r_pos == LastPos) ? '0 : r_pos + Index_width'(1);

    always_comb begin
        w_emit      = 1'b0;
        w_emit_val  = r_hold;
        w_consume   = 1'b0;
        w_pos_nxt   = r_pos;
        w_state_nxt = r_state;
        if (w_adv) begin
            if (r_state == DRAIN) begin
                w_emit    = 1'b1;
                w_pos_nxt = w_pos_inc;
                if (r_pos == LastPos) begin
                    w_state_nxt = RUN;
                end
            end else if (w_buf_valid) begin
                w_emit    = 1'b1;
                w_pos_nxt = w_pos_inc;
                if (w_buf_idx == r_pos) begin
                    w_emit_val = w_buf_val;
                    w_consume  = 1'b1;
                    // A last token at the final position just wraps; earlier ones pad the frame.
                    if (w_buf_last && (r_pos != LastPos)) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
        end
    end

    // Ordering is judged against the position after this cycle's advance, so a
    // token accepted alongside a consume must lie beyond the sample just emitted.
    assign w_tok_idx   = tok_i[Index_width-1:0];
    assign w_tok_bad   = (w_tok_idx < w_pos_nxt) || (w_tok_idx > LastPos);
    assign w_accept    = tok_valid_i && w_buf_ready;
    assign w_store     = w_accept && !w_tok_bad;
    assign tok_ready_o = w_buf_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= RUN;
            r_pos    <= '0;
            r_hold   <= '0;
            r_sample <= '0;
            r_idx    <= '0;
            r_last   <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
            if (w_consume) begin
                r_hold <= w_buf_val;
            end
            if (w_adv) begin
                r_valid <= w_emit;
                if (w_emit) begin
                    r_sample <= w_emit_val;
                    r_idx    <= r_pos;
                    r_last   <= (r_pos == LastPos);
                end
            end
            if (w_accept && w_tok_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign sample_o       = r_sample;
    assign sample_idx_o   = r_idx;
    assign sample_last_o  = r_last;
    assign sample_valid_o = r_valid;
    assign err_o          = r_err;

endmodule

// File: tb/tb_lava_decoder.sv
// tb_lava_decoder: scoreboard bench for lava_decoder (8 samples/frame, 10-bit data).
// Expected samples come from a frame-level sample-and-hold model; a monitor
// pops and compares on every sample handshake.
module tb_lava_decoder;

    localparam int DW = 10;
    localparam int N  = 8;
    localparam int IW = 3;

    typedef struct packed {
        logic [DW-1:0] v;
        logic [IW-1:0] i;
        logic          l;
    } smp_t;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic [DW+IW-1:0] tok_i = '0;
    logic           tok_last_i = 1'b0;
    logic           tok_valid_i = 1'b0;
    logic           tok_ready_o;
    logic [DW-1:0]  sample_o;
    logic [IW-1:0]  sample_idx_o;
    logic           sample_last_o;
    logic           sample_valid_o;
    logic           sample_ready_i = 1'b1;
    logic           err_o;

    lava_decoder #(
        .Data_bits(DW),
        .Samples_per_channel(N)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .tok_i         (tok_i),
        .tok_last_i    (tok_last_i),
        .tok_valid_i   (tok_valid_i),
        .tok_ready_o   (tok_ready_o),
        .sample_o      (sample_o),
        .sample_idx_o  (sample_idx_o),
        .sample_last_o (sample_last_o),
        .sample_valid_o(sample_valid_o),
        .sample_ready_i(sample_ready_i),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    smp_t exp_q[$];
    bit   sb_en = 1'b1;
    bit   rand_mode = 1'b0;
    int   stall_left = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   t7 = 0;
    int   hold_m = 0;
    int   ft[N];

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every accepted sample must match the head of the expected queue.
    always @(negedge clk) begin : mon
        smp_t e;
        if (rst_ni && sb_en && sample_valid_o && sample_ready_i) begin
            if (int'(sample_idx_o) == 0)     t0 = cyc;
            if (int'(sample_idx_o) == N - 1) t7 = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_sample", int'(sample_idx_o), -1);
            end else begin
                e = exp_q.pop_front();
                chk("sample_val",  int'(sample_o),      int'(e.v));
                chk("sample_idx",  int'(sample_idx_o),  int'(e.i));
                chk("sample_last", int'(sample_last_o), int'(e.l));
            end
        end
    end

    // Downstream ready driver; optionally stalls while position 2 is presented.
    always @(posedge clk) begin
        #1;
        if (stall_left > 0 && sample_valid_o && int'(sample_idx_o) == 2) begin
            sample_ready_i = 1'b0;
            stall_left--;
            @(negedge clk);
            chk("stall_valid",     int'(sample_valid_o), 1);
            chk("stall_val",       int'(sample_o),       100);
            chk("stall_idx",       int'(sample_idx_o),   2);
            chk("stall_tok_ready", int'(tok_ready_o),    0);
        end else begin
            sample_ready_i = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    function automatic void clear_frame();
        for (int p = 0; p < N; p++) ft[p] = -1;
    endfunction

    // Reference: each position takes the newest retained value at or before it,
    // otherwise the value carried from earlier positions/frames.
    function automatic void expand_frame();
        smp_t s;
        for (int p = 0; p < N; p++) begin
            if (ft[p] >= 0) hold_m = ft[p];
            s.v = DW'(hold_m);
            s.i = IW'(p);
            s.l = (p == N - 1);
            exp_q.push_back(s);
        end
    endfunction

    // Called and returns at posedge+#1.
    task automatic send(input int v, input int idx, input bit last);
        int k;
        tok_i       = {DW'(v), IW'(idx)};
        tok_last_i  = last;
        tok_valid_i = 1'b1;
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (tok_ready_o) break;
        end
        if (k == 1000) chk("tok_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        tok_valid_i = 1'b0;
        tok_last_i  = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 1000 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        hold_m = 0;
        exp_q.delete();
    endtask

    initial begin
        int k;
        int kind;
        int e;
        bit lst;
        int last_p;
        smp_t s;

        // 1: reset state
        do_reset();
        @(negedge clk);
        chk("rst_valid",     int'(sample_valid_o), 0);
        chk("rst_err",       int'(err_o),          0);
        chk("rst_tok_ready", int'(tok_ready_o),    1);
        chk("rst_sample",    int'(sample_o),       0);
        chk("rst_idx",       int'(sample_idx_o),   0);
        chk("rst_last",      int'(sample_last_o),  0);
        @(posedge clk);
        #1;

        // 2: basic expansion, full throughput
        clear_frame(); ft[0] = 100; ft[3] = 300; ft[6] = 50;
        expand_frame();
        send(100, 0, 0); send(300, 3, 0); send(50, 6, 1);
        wait_drain();
        chk("no_gap_frame", t7 - t0, N - 1);

        // 3: downstream stall while position 2 is presented
        stall_left = 3;
        clear_frame(); ft[0] = 100; ft[3] = 300; ft[6] = 50;
        expand_frame();
        send(100, 0, 0); send(300, 3, 0); send(50, 6, 1);
        wait_drain();
        chk("stall_applied", stall_left, 0);

        // 4: out-of-order token is flagged and dropped
        clear_frame(); ft[0] = 7; ft[5] = 9; ft[7] = 11;
        expand_frame();
        send(7, 0, 0); send(9, 5, 0);
        chk("err_before", int'(err_o), 0);
        send(4, 2, 0);
        chk("err_after", int'(err_o), 1);
        send(11, 7, 1);
        wait_drain();
        chk("err_sticky", int'(err_o), 1);

        // 5: last token at final position wraps straight into the next frame
        do_reset();
        @(posedge clk);
        #1;
        clear_frame(); ft[0] = 20; ft[7] = 30;
        expand_frame();
        clear_frame(); ft[0] = 40; ft[6] = 45;
        for (int p = 0; p < N - 1; p++) begin
            if (ft[p] >= 0) hold_m = ft[p];
            s.v = DW'(hold_m); s.i = IW'(p); s.l = 1'b0;
            exp_q.push_back(s);
        end
        send(20, 0, 0); send(30, 7, 1); send(40, 0, 0); send(45, 6, 0);
        wait_drain();
        chk("wrap_no_gap", t0 - t7, 1);
        s.v = DW'(46); s.i = IW'(N - 1); s.l = 1'b1;
        exp_q.push_back(s);
        hold_m = 46;
        send(46, 7, 0);
        wait_drain();

        // 6: asynchronous reset in the middle of a frame
        sb_en = 1'b0;
        send(60, 0, 0); send(61, 6, 0);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sample_valid_o && int'(sample_idx_o) == 4) break;
        end
        chk("reach_idx4", int'(sample_idx_o), 4);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_valid",     int'(sample_valid_o), 0);
        chk("arst_sample",    int'(sample_o),       0);
        chk("arst_idx",       int'(sample_idx_o),   0);
        chk("arst_last",      int'(sample_last_o),  0);
        chk("arst_err",       int'(err_o),          0);
        chk("arst_tok_ready", int'(tok_ready_o),    1);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        hold_m = 0;
        exp_q.delete();
        sb_en = 1'b1;
        s.v = DW'(55); s.i = '0; s.l = 1'b0;
        exp_q.push_back(s);
        send(55, 0, 0);
        wait_drain();

        // Randomized frames with random downstream back-pressure
        do_reset();
        @(posedge clk);
        #1;
        rand_mode = 1'b1;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 2);
            clear_frame();
            for (int p = 0; p < N - 1; p++)
                if ($urandom_range(0, 2) == 0) ft[p] = $urandom_range(0, 1023);
            if (kind < 2) begin
                ft[N - 1] = $urandom_range(0, 1023);
                last_p = N - 1;
                lst = $urandom_range(0, 1) != 0;
            end else begin
                e = $urandom_range(0, N - 2);
                ft[e] = $urandom_range(0, 1023);
                for (int p = e + 1; p < N; p++) ft[p] = -1;
                last_p = e;
                lst = 1'b1;
            end
            expand_frame();
            for (int p = 0; p < N; p++)
                if (ft[p] >= 0) send(ft[p], p, (p == last_p) ? lst : 1'b0);
            if (kind == 2) wait_drain();
        end
        wait_drain();
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_err", int'(err_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
